// File: rtl/mem_bus_arbiter.sv
// ---------------------------------------------------------------------------
// mem_bus_arbiter
//
// Shares the single memory/device bus (address, data, mem_enable, data_in
// direction) among NUM_REQ masters: CPU FSM, DMA engine, VGA framebuffer
// fetch. Round-robin arbitration, an optional per-owner bus lock, and one
// idle turnaround cycle between owners so tri-state drivers never overlap.
//
// Optional feature macro: MEM_ARB_TIMEOUT_EN
//   defined   : an owner holding the bus for MAX_HOLD unlocked cycles while
//               someone else is waiting is forced off (timeout pulse).
//   undefined : no hold counter, timeout tied low.
//
// Ports
//   clk         in   system clock (clk_100 domain)
//   reset       in   synchronous, active-high reset
//   req         in   [NUM_REQ]  per-requester request level
//   lock        in   [NUM_REQ]  owner keeps the bus while its bit is high
//   done        in   [NUM_REQ]  one-cycle release pulse from the owner
//   grant       out  [NUM_REQ]  one-hot ownership (gates bus drivers)
//   grant_valid out  any grant bit high
//   grant_id    out  [ID_WIDTH] binary owner index, holds last owner
//   bus_idle    out  high in IDLE and TURN; forces DEVICE_MAP enable low
//   timeout     out  one-cycle pulse on forced release
//   state_dbg   out  [2] current FSM state (0=IDLE, 1=OWN, 2=TURN)
//
// Handshake: a master raises req and keeps it high; it may drive the bus
// only while its grant bit is high; it ends ownership by pulsing done for
// one cycle or by dropping req. grant is registered, so it appears one
// cycle after req is sampled in IDLE and drops one cycle after release.
// ---------------------------------------------------------------------------
module mem_bus_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int MAX_HOLD = 32,
    parameter int ID_WIDTH = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_REQ-1:0]  req,
    input  logic [NUM_REQ-1:0]  lock,
    input  logic [NUM_REQ-1:0]  done,
    output logic [NUM_REQ-1:0]  grant,
    output logic                grant_valid,
    output logic [ID_WIDTH-1:0] grant_id,
    output logic                bus_idle,
    output logic                timeout,
    output logic [1:0]          state_dbg
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN  = 2'd1,
        ST_TURN = 2'd2
    } state_t;

    state_t              state;
    logic [ID_WIDTH-1:0] last_ptr;

    // Round-robin winner: first req above last_ptr, else first at/below it.
    logic                found_hi;
    logic                found_lo;
    logic [ID_WIDTH-1:0] idx_hi;
    logic [ID_WIDTH-1:0] idx_lo;
    logic                win_found;
    logic [ID_WIDTH-1:0] win_idx;

    always_comb begin
        found_hi = 1'b0;
        found_lo = 1'b0;
        idx_hi   = '0;
        idx_lo   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req[i] && (i > int'(last_ptr)) && !found_hi) begin
                found_hi = 1'b1;
                idx_hi   = ID_WIDTH'(i);
            end
            if (req[i] && (i <= int'(last_ptr)) && !found_lo) begin
                found_lo = 1'b1;
                idx_lo   = ID_WIDTH'(i);
            end
        end
    end

    assign win_found = found_hi | found_lo;
    assign win_idx   = found_hi ? idx_hi : idx_lo;

    // Owner-qualified inputs; grant is one-hot so masking selects the owner
    // and ignores done/req activity from everyone else.
    logic own_done;
    logic own_req;
    logic others_req;
    logic vol_rel;
    logic force_rel;

    assign own_done   = |(done & grant);
    assign own_req    = |(req & grant);
    assign others_req = |(req & ~grant);
    assign vol_rel    = own_done | ~own_req;

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int HOLD_W = $clog2(MAX_HOLD + 1);

    logic [HOLD_W-1:0] hold_cnt;
    logic [HOLD_W-1:0] hold_next;
    logic              own_lock;

    assign own_lock  = |(lock & grant);
    // Saturating count of the cycle being completed.
    assign hold_next = (hold_cnt == HOLD_W'(MAX_HOLD)) ? hold_cnt : hold_cnt + 1'b1;
    assign force_rel = (state == ST_OWN) && !own_lock &&
                       (hold_next == HOLD_W'(MAX_HOLD)) && others_req;

    always_ff @(posedge clk) begin
        if (reset) begin
            hold_cnt <= '0;
            timeout  <= 1'b0;
        end else begin
            timeout <= 1'b0;
            if (state == ST_IDLE) begin
                hold_cnt <= '0;
            end else if (state == ST_OWN) begin
                if (own_lock) begin
                    hold_cnt <= '0;
                end else begin
                    hold_cnt <= hold_next;
                end
                // Pulse only when the eviction is what ends ownership.
                if (force_rel && !vol_rel) begin
                    timeout <= 1'b1;
                end
            end
        end
    end
`else
    logic unused_lock;
    localparam int unused_max_hold = MAX_HOLD;

    assign unused_lock = ^lock;
    assign force_rel   = 1'b0;
    assign timeout     = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            grant       <= '0;
            grant_valid <= 1'b0;
            grant_id    <= '0;
            bus_idle    <= 1'b1;
            last_ptr    <= ID_WIDTH'(NUM_REQ - 1);
        end else begin
            case (state)
                ST_IDLE: begin
                    if (win_found) begin
                        state       <= ST_OWN;
                        grant       <= NUM_REQ'(1) << win_idx;
                        grant_valid <= 1'b1;
                        grant_id    <= win_idx;
                        bus_idle    <= 1'b0;
                        last_ptr    <= win_idx;
                    end
                end
                ST_OWN: begin
                    // last_ptr already points at the owner, so an evicted
                    // owner automatically goes to the back of the queue.
                    if (vol_rel || force_rel) begin
                        state       <= ST_TURN;
                        grant       <= '0;
                        grant_valid <= 1'b0;
                        bus_idle    <= 1'b1;
                    end
                end
                ST_TURN: begin
                    // Bus undriven for this cycle; arbitration resumes in IDLE.
                    state <= ST_IDLE;
                end
                default: begin
                    state       <= ST_IDLE;
                    grant       <= '0;
                    grant_valid <= 1'b0;
                    bus_idle    <= 1'b1;
                end
            endcase
        end
    end

    assign state_dbg = state;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_bus_arbiter
//
// Directed scenarios followed by random traffic. A behavioural model tracks
// the current owner, a "bus must stay free" countdown after each release,
// and the round-robin pointer; expected outputs go into exp_q and are popped
// one cycle at a time against the DUT.
// ---------------------------------------------------------------------------
module tb_mem_bus_arbiter;

    localparam int NR  = 4;
    localparam int MH  = 8;
    localparam int IDW = 2;
    localparam int EW  = NR + IDW + 3;

`ifdef MEM_ARB_TIMEOUT_EN
    localparam bit TO_EN    = 1'b1;
    localparam int EXP_HELD = MH - 1;
`else
    localparam bit TO_EN    = 1'b0;
    localparam int EXP_HELD = 100;
`endif

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           reset = 1'b1;
    logic [NR-1:0]  req   = '0;
    logic [NR-1:0]  lock  = '0;
    logic [NR-1:0]  done  = '0;
    logic [NR-1:0]  grant;
    logic           grant_valid;
    logic [IDW-1:0] grant_id;
    logic           bus_idle;
    logic           timeout;
    logic [1:0]     state_dbg;

    mem_bus_arbiter #(
        .NUM_REQ  (NR),
        .MAX_HOLD (MH),
        .ID_WIDTH (IDW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req         (req),
        .lock        (lock),
        .done        (done),
        .grant       (grant),
        .grant_valid (grant_valid),
        .grant_id    (grant_id),
        .bus_idle    (bus_idle),
        .timeout     (timeout),
        .state_dbg   (state_dbg)
    );

    int compared   = 0;
    int mismatched = 0;

    // ---------------- reference model ----------------
    int m_owner = -1;   // -1: nobody owns the bus
    int m_block = 0;    // edges that must pass before arbitration is allowed
    int m_last  = NR - 1;
    int m_gid   = 0;
    int m_run   = 0;    // consecutive unlocked owned cycles
    bit m_to    = 1'b0;

    logic [EW-1:0] exp_q[$];

    task automatic model_step();
        logic [NR-1:0] mask;
        bit            got;
        if (reset) begin
            m_owner = -1;
            m_block = 0;
            m_last  = NR - 1;
            m_gid   = 0;
            m_run   = 0;
            m_to    = 1'b0;
        end else begin
            m_to = 1'b0;
            if (m_owner >= 0) begin
                mask = NR'(1) << m_owner;
                if (lock[m_owner]) m_run = 0;
                else if (m_run < MH) m_run++;
                if (done[m_owner] || !req[m_owner]) begin
                    m_owner = -1;
                    m_block = 1;
                end else if (TO_EN && !lock[m_owner] && m_run >= MH && (req & ~mask) != '0) begin
                    m_owner = -1;
                    m_block = 1;
                    m_to    = 1'b1;
                end
            end else if (m_block > 0) begin
                m_block--;
            end else begin
                got = 1'b0;
                for (int k = 1; k <= NR; k++) begin
                    int c;
                    c = (m_last + k) % NR;
                    if (!got && req[c]) begin
                        got     = 1'b1;
                        m_owner = c;
                        m_last  = c;
                        m_gid   = c;
                        m_run   = 0;
                    end
                end
            end
        end
        if (m_owner >= 0) mask = NR'(1) << m_owner;
        else mask = '0;
        exp_q.push_back({m_to, (m_owner < 0), IDW'(m_gid), (m_owner >= 0), mask});
    endtask

    // ---------------- scoreboard ----------------
    task automatic expect_bits(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_outputs();
        logic [EW-1:0] e;
        e = exp_q.pop_front();
        expect_bits("grant",       32'(grant),       32'(e[NR-1:0]));
        expect_bits("grant_valid", 32'(grant_valid), 32'(e[NR]));
        expect_bits("grant_id",    32'(grant_id),    32'(e[NR+IDW:NR+1]));
        expect_bits("bus_idle",    32'(bus_idle),    32'(e[NR+IDW+1]));
        expect_bits("timeout",     32'(timeout),     32'(e[NR+IDW+2]));
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check_outputs();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req   = '0;
        lock  = '0;
        done  = '0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic wait_grant(output int gap);
        gap = 0;
        while (grant_valid !== 1'b1 && gap < 10) begin
            tick();
            gap++;
        end
        expect_bits("wait_grant", 32'(grant_valid), 32'd1);
    endtask

    // ---------------- stimulus ----------------
    logic [NR-1:0] exp_order[5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [NR-1:0] seen;

    initial begin
        int gap;
        int held;
        logic to_seen;

        // Reset state and a single request/release.
        do_reset();
        expect_bits("rst_grant", 32'(grant), 32'd0);
        expect_bits("rst_idle", 32'(bus_idle), 32'd1);
        req = 4'b0001;
        tick();
        expect_bits("t1_grant", 32'(grant), 32'b0001);
        expect_bits("t1_id", 32'(grant_id), 32'd0);
        expect_bits("t1_idle", 32'(bus_idle), 32'd0);
        done = 4'b0001;
        req  = 4'b0000;
        tick();
        done = '0;
        expect_bits("t1_rel_grant", 32'(grant), 32'd0);
        expect_bits("t1_turn_idle", 32'(bus_idle), 32'd1);
        tick();
        expect_bits("t1_after_idle", 32'(bus_idle), 32'd1);

        // All four requesting: strict rotation with two idle cycles between.
        do_reset();
        req = 4'b1111;
        for (int n = 0; n < 5; n++) begin
            wait_grant(gap);
            seen = grant;
            expect_bits("rr_order", 32'(seen), 32'(exp_order[n]));
            if (n > 0) expect_bits("rr_gap", 32'(gap), 32'd2);
            tick();
            tick();
            done = NR'(1) << m_owner;
            tick();
            done = '0;
        end
        req = '0;
        tick();
        tick();

        // Owner 2 drops req with no done; search wraps from 3 to 0.
        do_reset();
        req = 4'b0100;
        tick();
        expect_bits("t3_own2", 32'(grant), 32'b0100);
        req = 4'b0101;
        tick();
        expect_bits("t3_hold2", 32'(grant), 32'b0100);
        req = 4'b0001;
        tick();
        expect_bits("t3_release", 32'(grant), 32'd0);
        tick();
        expect_bits("t3_idle", 32'(grant), 32'd0);
        tick();
        expect_bits("t3_wrap", 32'(grant), 32'b0001);
        expect_bits("t3_wrap_id", 32'(grant_id), 32'd0);

        // Reset mid-ownership: no turnaround afterwards.
        do_reset();
        req = 4'b0100;
        tick();
        expect_bits("t4_own2", 32'(grant), 32'b0100);
        reset = 1'b1;
        req   = '0;
        tick();
        expect_bits("t4_rst_grant", 32'(grant), 32'd0);
        expect_bits("t4_rst_id", 32'(grant_id), 32'd0);
        reset = 1'b0;
        req   = 4'b0001;
        tick();
        expect_bits("t4_no_turn", 32'(grant), 32'b0001);

        // Owner 1 unlocked with requester 3 waiting.
        do_reset();
        req = 4'b0010;
        tick();
        expect_bits("t5_own1", 32'(grant), 32'b0010);
        req     = 4'b1010;
        held    = 0;
        to_seen = 1'b0;
        for (int c = 0; c < 100; c++) begin
            tick();
            if (grant !== 4'b0010) begin
                to_seen = timeout;
                break;
            end
            held++;
        end
        expect_bits("t5_hold_len", 32'(held), 32'(EXP_HELD));
`ifdef MEM_ARB_TIMEOUT_EN
        expect_bits("t5_timeout", 32'(to_seen), 32'd1);
        tick();
        tick();
        expect_bits("t5_next_owner", 32'(grant), 32'b1000);
`endif

        // Same with lock[1] high: never evicted.
        do_reset();
        req = 4'b0010;
        tick();
        req  = 4'b1010;
        lock = 4'b0010;
        held = 0;
        for (int c = 0; c < 100; c++) begin
            tick();
            if (grant !== 4'b0010) break;
            held++;
        end
        expect_bits("t5_lock_len", 32'(held), 32'd100);

        // Random traffic against the model.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            reset = ($urandom_range(0, 99) == 0);
            for (int i = 0; i < NR; i++) begin
                if ($urandom_range(0, 9) == 0) req[i] = ~req[i];
            end
            done = '0;
            if ($urandom_range(0, 5) == 0) done = NR'($urandom_range(0, 15));
            if ($urandom_range(0, 15) == 0) lock = NR'($urandom_range(0, 15));
            tick();
        end

        // ---------------- report ----------------
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares the single memory/device bus among up to NUM_REQ masters: the CPU FSM, a planned DMA engine and the VGA framebuffer fetch.
- The shared bus comprises address bus, data bus, mem_enable and data_in direction.
- Round-robin request/grant arbitration with optional bus lock.
- Inserts one idle turnaround cycle between owners so tri-state drivers never overlap.
- Sits between the requesters and DEVICE_MAP; gates each requester's bus drivers via its grant bit.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- MAX_HOLD, 32, max consecutive owned cycles before forced release (timeout feature only).
- ID_WIDTH, 2, width of grant_id; must satisfy 2**ID_WIDTH >= NUM_REQ.

Ports:
- clk  in  1  system clock (clk_100 domain).
- reset  in  1  synchronous, active-high reset.
- req  in  NUM_REQ  per-requester request level; held high until release.
- lock  in  NUM_REQ  owner holds bus regardless of other requests or timeout while its bit is high.
- done  in  NUM_REQ  one-cycle release pulse from the current owner.
- grant  out  NUM_REQ  one-hot ownership; owner may drive the bus only while its bit is high.
- grant_valid  out  1  high while any grant bit is high.
- grant_id  out  ID_WIDTH  binary index of the owner; holds the last owner when idle.
- bus_idle  out  1  high in IDLE and TURN; DEVICE_MAP enable is forced low when high.
- timeout  out  1  one-cycle pulse on forced release.

Behaviour:
- Registered outputs. Reset values: grant=0, grant_valid=0, grant_id=0, bus_idle=1, timeout=0, last-owner pointer=NUM_REQ-1, hold counter=0.
- Reset mid-ownership drops grant on the cycle after reset is sampled. No turnaround cycle is inserted after reset.
- States:
  - IDLE: if any req is set, pick the winner and go to OWN; grant is registered, so it appears 1 cycle after req is sampled.
  - OWN: the owner's grant bit is high.
  - TURN: exactly one cycle, grant=0, then go to IDLE.
- Winner selection: first set req bit searching upward from (last+1) mod NUM_REQ, wrapping. On grant, last = winner.
- OWN exits to TURN when any of these occurs: done[owner] pulses; req[owner] drops; or the timeout condition (below) is met.
- done or req changes from non-owners are ignored. A done pulse while idle is ignored.
- Simultaneous done[owner] and new requests: TURN still occurs; the new arbitration happens in IDLE, so the minimum gap between owners is 2 cycles (TURN + IDLE evaluation).
- Same requester re-requesting right after release is allowed; round-robin only lets it win again if no other req is set.
- Hold counter:
  - Counts cycles in OWN: 0 on entry, saturates at MAX_HOLD.
  - Resets to 0 whenever lock[owner] is high.
- The bus_idle fall edge coincides with grant_valid rising.
- grant_id is updated when the grant is issued; it is stable throughout OWN and TURN.

Optional Feature:
- Macro: MEM_ARB_TIMEOUT_EN.
- Defined: in OWN, when the hold counter reaches MAX_HOLD, lock[owner]=0, and any other req bit is set, force TURN. timeout pulses high for 1 cycle, coincident with grant dropping. last = the evicted owner, so it goes to the back of the queue.
- Not defined: no counter and no forced release; timeout is tied to 0; the owner holds the bus until done or req drop.

Test Plan:
- Reset, then req=4'b0001: grant=0001 exactly 1 cycle later, grant_id=0, bus_idle=0; done[0] pulse -> grant=0 next cycle, 1 TURN cycle, bus_idle=1.
- req=4'b1111 held, each owner pulses done 3 cycles after grant: grant order 0001,0010,0100,1000,0001; always 2 idle cycles between grants.
- Owner 2 active, req=4'b0101, owner 2 drops req without done: release via TURN, then grant 0001 (search wraps from index 3 to 0).
- Reset asserted while grant=0100: grant=0, grant_id=0 next cycle; next req=4'b0001 is granted with no TURN cycle.
- MEM_ARB_TIMEOUT_EN, MAX_HOLD=8: owner 1 with lock=0 and req[3]=1 -> timeout pulse and grant drop on owned cycle 8, then grant=1000. Repeat with lock[1]=1 -> no timeout over 100 cycles.
- Without MEM_ARB_TIMEOUT_EN: same stimulus -> owner 1 retains grant for 100 cycles, timeout stays 0.
